// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives an external Montgomery multiplier; every operand is latched at start.
module mod_exp_ctrl #(
    parameter int unsigned NBITS  = 2048,
    parameter int unsigned EWIDTH = $clog2(NBITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_p,
    input  logic [NBITS-1:0]  base_m,
    input  logic [NBITS-1:0]  one_m,
    input  logic [NBITS-1:0]  exp,
    input  logic [EWIDTH-1:0] exp_size,
    input  logic [NBITS-1:0]  m,
    input  logic [NBITS-1:0]  m_size,
    output logic [NBITS-1:0]  y,
    output logic              done_irq_p,
    output logic              busy,
    output logic              mm_enable_p,
    output logic [NBITS-1:0]  mm_a,
    output logic [NBITS-1:0]  mm_b,
    output logic [NBITS-1:0]  mm_m,
    output logic [NBITS-1:0]  mm_m_size,
    input  logic [NBITS-1:0]  mm_y,
    input  logic              mm_done_irq_p
);

    typedef enum logic [2:0] {
        StIdle,
        StSqrIssue,
        StSqrWait,
        StMulIssue,
        StMulWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NBITS-1:0]  acc_q, acc_d;
    logic [NBITS-1:0]  y_q, y_d;
    logic [NBITS-1:0]  base_q, base_d;
    logic [NBITS-1:0]  exp_q, exp_d;
    logic [NBITS-1:0]  m_q, m_d;
    logic [NBITS-1:0]  msize_q, msize_d;
    logic [EWIDTH-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            y_q     <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            m_q     <= '0;
            msize_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            m_q     <= m_d;
            msize_q <= msize_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        y_d     = y_q;
        base_d  = base_q;
        exp_d   = exp_q;
        m_d     = m_q;
        msize_d = msize_q;
        idx_d   = idx_q;

        unique case (state_q)
            StIdle: begin
                if (enable_p) begin
                    base_d  = base_m;
                    exp_d   = exp;
                    m_d     = m;
                    msize_d = m_size;
                    acc_d   = one_m;
                    idx_d   = exp_size;
                    state_d = StSqrIssue;
                end
            end
            StSqrIssue: state_d = StSqrWait;
            StSqrWait: begin
                if (mm_done_irq_p) begin
                    acc_d = mm_y;
                    if (exp_q[idx_q]) begin
                        state_d = StMulIssue;
                    end else if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - EWIDTH'(1);
                        state_d = StSqrIssue;
                    end
                end
            end
            StMulIssue: state_d = StMulWait;
            StMulWait: begin
                if (mm_done_irq_p) begin
                    acc_d = mm_y;
                    if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - EWIDTH'(1);
                        state_d = StSqrIssue;
                    end
                end
            end
            StDone: begin
                y_d     = acc_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operands come straight from registers that only change on the done cycle edge,
    // so they stay stable across the whole multiply.
    always_comb begin
        busy        = (state_q != StIdle);
        done_irq_p  = (state_q == StDone);
        mm_enable_p = (state_q == StSqrIssue) || (state_q == StMulIssue);
        mm_a        = acc_q;
        mm_b        = ((state_q == StMulIssue) || (state_q == StMulWait)) ? base_q : acc_q;
        mm_m        = m_q;
        mm_m_size   = msize_q;
        y           = y_q;
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a behavioural Montgomery multiplier of configurable latency.
module tb_mod_exp_ctrl;

    localparam int unsigned NB = 64;
    localparam int unsigned EW = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_p;
    logic [NB-1:0] base_m, one_m, exp, m, m_size;
    logic [EW-1:0] exp_size;
    logic [NB-1:0] y, mm_a, mm_b, mm_m, mm_m_size, mm_y;
    logic          done_irq_p, busy, mm_enable_p, mm_done_irq_p;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.NBITS(NB), .EWIDTH(EW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_p      (enable_p),
        .base_m        (base_m),
        .one_m         (one_m),
        .exp           (exp),
        .exp_size      (exp_size),
        .m             (m),
        .m_size        (m_size),
        .y             (y),
        .done_irq_p    (done_irq_p),
        .busy          (busy),
        .mm_enable_p   (mm_enable_p),
        .mm_a          (mm_a),
        .mm_b          (mm_b),
        .mm_m          (mm_m),
        .mm_m_size     (mm_m_size),
        .mm_y          (mm_y),
        .mm_done_irq_p (mm_done_irq_p)
    );

    // a*b*2^-ms mod mv by halving, mv odd
    function automatic logic [NB-1:0] mm_f(input logic [NB-1:0] a, b, mv, ms);
        logic [2*NB:0] p;
        p = (129'(a) * 129'(b)) % 129'(mv);
        for (int i = 0; i < 64; i++) begin
            if (64'(i) < ms) begin
                if (p[0]) p = p + 129'(mv);
                p = p >> 1;
            end
        end
        return p[NB-1:0];
    endfunction

    // Multiplier model
    int            lat_cfg = 1;
    int            mcnt = 0;
    int            stab_bad = 0;
    logic          mdl_done = 1'b0;
    logic [NB-1:0] mdl_y = '0, mres = '0;
    logic [NB-1:0] ca = '0, cb = '0, cm = '0, cms = '0;
    logic          stray = 1'b0;
    logic [NB-1:0] stray_y = 64'hDEAD_BEEF;

    assign mm_done_irq_p = mdl_done | stray;
    assign mm_y          = stray ? stray_y : mdl_y;

    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt     = 0;
            mdl_done = 1'b0;
        end else begin
            mdl_done = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    mdl_done = 1'b1;
                    mdl_y    = mres;
                    if (mm_a !== ca || mm_b !== cb || mm_m !== cm || mm_m_size !== cms)
                        stab_bad = stab_bad + 1;
                end
            end
            if (mm_enable_p) begin
                ca   = mm_a;
                cb   = mm_b;
                cm   = mm_m;
                cms  = mm_m_size;
                mres = mm_f(mm_a, mm_b, mm_m, mm_m_size);
                mcnt = lat_cfg;
            end
        end
    end

    // Cycle monitor: pulse counts and one-cycle turnaround
    int mm_pulses = 0;
    int dones = 0;
    int gap_bad = 0;
    bit en_pend = 1'b0, gap_pend = 1'b0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            en_pend  = 1'b0;
            gap_pend = 1'b0;
        end else begin
            if (en_pend && !mm_enable_p) gap_bad = gap_bad + 1;
            if (gap_pend && !(mm_enable_p || done_irq_p)) gap_bad = gap_bad + 1;
            en_pend  = enable_p && !busy;
            gap_pend = mm_done_irq_p && busy;
            if (mm_enable_p) mm_pulses = mm_pulses + 1;
            if (done_irq_p) dones = dones + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic run_op(input logic [NB-1:0] b, input logic [NB-1:0] one,
                          input logic [NB-1:0] e, input int esz,
                          input logic [NB-1:0] mv, input logic [NB-1:0] msz,
                          input int lat, input bit rel, input bit rep,
                          output logic [NB-1:0] yv, output int np, output int nd,
                          output int ng, output bit busy_ok, output bit tmo);
        int p0, d0, g0;
        bit did;
        did = 1'b0;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        lat_cfg  = lat;
        p0       = mm_pulses;
        d0       = dones;
        g0       = gap_bad + stab_bad;
        base_m   = b;
        one_m    = one;
        exp      = e;
        exp_size = EW'(esz);
        m        = mv;
        m_size   = msz;
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        #2;
        busy_ok = busy;
        tmo = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            #2;
            if (dones > d0) begin
                tmo = 1'b0;
                break;
            end
            if (rep && !did && (mm_pulses - p0) == 2) begin
                did = 1'b1;
                @(negedge clk);
                enable_p = 1'b1;
                base_m   = 64'd7;
                one_m    = 64'd5;
                exp      = 64'd0;
                exp_size = '0;
                m        = 64'd11;
                @(negedge clk);
                enable_p = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        #2;
        yv = y;
        np = mm_pulses - p0;
        nd = dones - d0;
        ng = gap_bad + stab_bad - g0;
    endtask

    typedef struct {
        logic [NB-1:0] e;
        int            esz;
        int            lat;
        logic [NB-1:0] y;
        int            pulses;
    } vec_t;

    vec_t          vecs[9];
    logic [NB-1:0] yv, gold, rm, rb, ro, re, mask;
    int            np, nd, ng, p0, esz, pc, lat;
    bit            bok, tmo, got_it;

    initial begin
        // m=13, R=16: one_m=3, base 5 -> 2
        vecs[0] = '{64'd3,    1, 1, 64'd11, 4};
        vecs[1] = '{64'd3,    1, 7, 64'd11, 4};
        vecs[2] = '{64'd0,    0, 2, 64'd3,  1};
        vecs[3] = '{64'd2,    1, 3, 64'd10, 3};
        vecs[4] = '{64'd1,    0, 1, 64'd2,  2};
        vecs[5] = '{64'd5,    2, 4, 64'd2,  5};
        vecs[6] = '{64'd2,    2, 2, 64'd10, 4};
        vecs[7] = '{64'd3,    2, 1, 64'd11, 5};
        vecs[8] = '{64'hF3,   1, 5, 64'd11, 4};

        rst_n    = 1'b0;
        enable_p = 1'b0;
        base_m   = '0;
        one_m    = '0;
        exp      = '0;
        exp_size = '0;
        m        = '0;
        m_size   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mm_en", 64'(mm_enable_p), 64'd0);
        chk("rst_done", 64'(done_irq_p), 64'd0);
        chk("rst_y", y, 64'd0);
        chk("rst_mm_a", mm_a, 64'd0);
        chk("rst_mm_m", mm_m, 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(64'd2, 64'd3, vecs[i].e, vecs[i].esz, 64'd13, 64'd4, vecs[i].lat,
                   (i == 0), 1'b0, yv, np, nd, ng, bok, tmo);
            chk($sformatf("v%0d_y", i), yv, vecs[i].y);
            chk($sformatf("v%0d_pulses", i), 64'(np), 64'(vecs[i].pulses));
            chk($sformatf("v%0d_dones", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_timing", i), 64'(ng), 64'd0);
            chk($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
            chk($sformatf("v%0d_timeout", i), 64'(tmo), 64'd0);
        end
        chk("idle_busy", 64'(busy), 64'd0);

        // Restart attempt with different operands mid-run
        run_op(64'd2, 64'd3, 64'd3, 1, 64'd13, 64'd4, 4, 1'b0, 1'b1, yv, np, nd, ng, bok, tmo);
        chk("repulse_y", yv, 64'd11);
        chk("repulse_pulses", 64'(np), 64'd4);
        chk("repulse_dones", 64'(nd), 64'd1);
        chk("repulse_timeout", 64'(tmo), 64'd0);

        // Reset during MUL_WAIT
        @(negedge clk);
        lat_cfg  = 6;
        p0       = mm_pulses;
        base_m   = 64'd2;
        one_m    = 64'd3;
        exp      = 64'd3;
        exp_size = EW'(1);
        m        = 64'd13;
        m_size   = 64'd4;
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        got_it = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #2;
            if ((mm_pulses - p0) == 2) begin
                got_it = 1'b1;
                break;
            end
        end
        chk("midrst_reach_mul", 64'(got_it), 64'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mm_en", 64'(mm_enable_p), 64'd0);
        chk("midrst_done", 64'(done_irq_p), 64'd0);
        chk("midrst_y", y, 64'd0);
        chk("midrst_mm_b", mm_b, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = mm_pulses;
        #2;
        stray = 1'b1;
        @(negedge clk);
        #2;
        stray = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_y", y, 64'd0);
        chk("stray_pulses", 64'(mm_pulses - p0), 64'd0);
        run_op(64'd2, 64'd3, 64'd3, 1, 64'd13, 64'd4, 3, 1'b0, 1'b0, yv, np, nd, ng, bok, tmo);
        chk("fresh_y", yv, 64'd11);
        chk("fresh_pulses", 64'(np), 64'd4);
        chk("fresh_timing", 64'(ng), 64'd0);

        // Random full-width operands against the reference chain
        for (int t = 0; t < 4; t++) begin
            rm   = {1'b1, 30'($urandom), $urandom, 1'b1};
            ro   = 64'(({65'd1, 64'd0}) % 129'(rm));
            rb   = {$urandom, $urandom} % rm;
            re   = {$urandom, $urandom};
            esz  = int'($urandom_range(0, 15));
            lat  = int'($urandom_range(1, 20));
            gold = ro;
            pc   = 0;
            for (int i = esz; i >= 0; i--) begin
                gold = mm_f(gold, gold, rm, 64'd64);
                if (re[i]) begin
                    gold = mm_f(gold, rb, rm, 64'd64);
                    pc = pc + 1;
                end
            end
            mask = '0;
            run_op(rb, ro, re, esz, rm, 64'd64, lat, 1'b0, 1'b0, yv, np, nd, ng, bok, tmo);
            chk($sformatf("rnd%0d_y", t), yv, gold);
            chk($sformatf("rnd%0d_pulses", t), 64'(np), 64'(esz + 1 + pc));
            chk($sformatf("rnd%0d_timing", t), 64'(ng), 64'd0);
            chk($sformatf("rnd%0d_timeout", t), 64'(tmo), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 2048: operand width; must match the attached montgomery_mul instance.
REQ-002 SHALL have parameter EWIDTH, default $clog2(NBITS): width of exp_size.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable_p  input  1  single-cycle start pulse.
REQ-006 base_m  input  NBITS  base, already in Montgomery domain.
REQ-007 one_m  input  NBITS  R mod m, the Montgomery-domain one.
REQ-008 exp  input  NBITS  exponent.
REQ-009 exp_size  input  EWIDTH  index of the highest exponent bit to scan.
REQ-010 m / m_size  input  NBITS / NBITS  modulus and modulus size, forwarded to the multiplier.
REQ-011 y  output  NBITS  result, in Montgomery domain.
REQ-012 done_irq_p  output  1  single-cycle completion pulse.
REQ-013 busy  output  1  high from the start cycle until the done cycle.
REQ-014 mm_enable_p  output  1  start pulse to montgomery_mul.
REQ-015 mm_a / mm_b / mm_m / mm_m_size  output  NBITS each  multiplier operands.
REQ-016 mm_y  input  NBITS  multiplier result.
REQ-017 mm_done_irq_p  input  1  multiplier completion pulse.

Function
REQ-018 SHALL compute y = MM-chain left-to-right square-and-multiply:
- acc = one_m
- for i = exp_size downto 0: acc = MM(acc, acc); if exp[i], acc = MM(acc, base_m)
- y = acc
REQ-019 SHALL implement FSM states IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT and DONE.
REQ-020 IDLE with enable_p=1 SHALL latch the following, then go to SQR_ISSUE:
- base_m, exp, exp_size, m, m_size into internal registers
- acc<=one_m; idx<=exp_size
REQ-021 IDLE with enable_p=0 SHALL hold all state.
REQ-022 SQR_ISSUE SHALL drive mm_enable_p=1 for exactly that cycle with mm_a=mm_b=acc, then go to SQR_WAIT.
REQ-023 MUL_ISSUE SHALL drive mm_enable_p=1 for exactly that cycle with mm_a=acc and mm_b=latched base, then go to MUL_WAIT.
REQ-024 mm_a, mm_b, mm_m and mm_m_size SHALL remain stable from the ISSUE cycle until the mm_done_irq_p cycle inclusive.
REQ-025 SQR_WAIT on mm_done_irq_p SHALL load acc<=mm_y, then:
- exp[idx]=1 -> MUL_ISSUE
- else idx==0 -> DONE
- else idx<=idx-1 and go to SQR_ISSUE
REQ-026 MUL_WAIT on mm_done_irq_p SHALL load acc<=mm_y, then:
- idx==0 -> DONE
- else idx<=idx-1 and go to SQR_ISSUE
REQ-027 DONE SHALL load y<=acc, assert done_irq_p for that one cycle, and return to IDLE.
REQ-028 y SHALL hold its value until the next DONE.
REQ-029 Latency overhead SHALL be exactly 1 cycle from enable_p to the first mm_enable_p, and 1 cycle from each mm_done_irq_p to the next mm_enable_p or to DONE.
REQ-030 The total number of mm_enable_p pulses SHALL equal (exp_size+1) + popcount(exp[exp_size:0]).
REQ-031 enable_p while busy=1 SHALL be ignored; latched operands SHALL stay unchanged.
REQ-032 mm_done_irq_p outside the WAIT states SHALL be ignored.
REQ-033 Live inputs SHALL NOT affect a running operation; only latched copies are used.
REQ-034 busy SHALL be 0 only in IDLE.

Reset
REQ-035 On rst_n=0, asynchronously and at any time including mid-operation, the block SHALL force:
- state=IDLE, acc=0, idx=0, y=0
- done_irq_p=0, busy=0, mm_enable_p=0
- mm_a=mm_b=mm_m=mm_m_size=0
REQ-036 After reset release the block SHALL accept enable_p on the first clock edge.

Verification
Bench pairs the block with a behavioural multiplier model: MM(a,b)=a*b*R^-1 mod m, done pulse L cycles after start, L configurable 1..20.
REQ-037 m=13, R=16, base_m=2 (5 in Montgomery form), one_m=3, exp=3, exp_size=1 -> 4 mm_enable_p pulses, y=11, one done_irq_p pulse.
REQ-038 Same setup with exp=0, exp_size=0 -> exactly 1 pulse, y=3.
REQ-039 exp=2, exp_size=1 (5^2=25) -> 3 pulses, y=12*16 mod 13=10.
REQ-040 enable_p re-pulsed with different operands during the second mm wait -> result unchanged (y=11), pulse count unchanged.
REQ-041 rst_n low during MUL_WAIT, then a fresh start -> the following are forced 0 immediately:
- mm_enable_p, busy, done_irq_p, y
Stray mm_done_irq_p in IDLE ignored; fresh run yields y=11.
REQ-042 Random NBITS=64 operands, L random -> y matches the reference model, and each mm gap is exactly 1 cycle.
